// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor: FSM state encoding,
// parameter defaults and the loss counter width.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  localparam int unsigned DEF_SYNC_STAGES         = 2;
  localparam int unsigned DEF_RST_PULSE_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 50000;
  localparam int unsigned DEF_STABLE_CYCLES       = 1024;
  localparam int unsigned DEF_MAX_RETRIES         = 7;
  localparam int unsigned DEF_CNT_W               = 16;
  localparam int unsigned LOSS_CNT_W              = 8;

endpackage

// File: rtl/pll_sup_sync.sv
// Multi-flop synchronizer bringing the asynchronous PLL locked flag into the
// reference clock domain. Cleared to 0 (not locked) by reset_n.
//   clk     : reference clock
//   reset_n : async active-low reset
//   din     : asynchronous input
//   dout    : synchronized output, STAGES clk edges of latency
module pll_sup_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/nios2_system_v0_pll_lock_supervisor.sv
// PLL lock supervisor running on the free-running reference clock. Pulses the
// PLL reset, waits for a synchronized lock, requires a stable lock window
// before releasing the system reset, relocks on loss or timeout and latches
// a failure after too many consecutive timeouts.
//   clk             : 50 MHz reference clock
//   reset_n         : async active-low reset
//   pll_locked      : PLL locked flag, asynchronous
//   force_relock    : 1-cycle request to restart the PLL from any state
//   pll_rst         : PLL reset, active high
//   sys_reset_n     : system reset request, active low (high only in RUN)
//   locked_stable   : high while in RUN
//   fail            : high while in FAIL
//   lock_loss_count : saturating count of unrequested lock losses in RUN
//   state_dbg       : current state encoding
module nios2_system_v0_pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned SYNC_STAGES         = DEF_SYNC_STAGES,
  parameter int unsigned RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned STABLE_CYCLES       = DEF_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int unsigned CNT_W               = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pll_locked,
  input  logic                  force_relock,
  output logic                  pll_rst,
  output logic                  sys_reset_n,
  output logic                  locked_stable,
  output logic                  fail,
  output logic [LOSS_CNT_W-1:0] lock_loss_count,
  output logic [2:0]            state_dbg
);

  // Retry counter must hold MAX_RETRIES+1 (the value that triggers FAIL).
  localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 2);

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  logic                  locked_s;
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      timer_q, timer_d;
  logic [RETRY_W-1:0]    retries_q, retries_d;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;
  logic                  pll_rst_q, pll_rst_d;
  logic                  sys_q, sys_d;
  logic                  ls_q, ls_d;
  logic                  fail_q, fail_d;

  pll_sup_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .din    (pll_locked),
    .dout   (locked_s)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    retries_d = retries_q;
    loss_d    = loss_q;

    case (state_q)
      ST_PLL_RST: begin
        if (timer_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = ST_STABLE;
          timer_d = '0;
        end else if (timer_q == TIMEOUT_LAST) begin
          timer_d   = '0;
          retries_d = retries_q + 1'b1;
          // retries+1 > MAX_RETRIES  <=>  retries >= MAX_RETRIES
          state_d   = (retries_q >= RETRY_LIMIT) ? ST_FAIL : ST_PLL_RST;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_STABLE: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          timer_d = '0;
        end else if (timer_q == STABLE_LAST) begin
          state_d   = ST_RUN;
          timer_d   = '0;
          retries_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d = ST_PLL_RST;
          timer_d = '0;
          if (loss_q != '1) begin
            loss_d = loss_q + 1'b1;
          end
        end
      end
      ST_FAIL: begin
      end
      default: begin
        state_d = ST_PLL_RST;
        timer_d = '0;
      end
    endcase

    // Relock request overrides the transition but keeps any loss counted above.
    if (force_relock) begin
      state_d = ST_PLL_RST;
      timer_d = '0;
      if (state_q == ST_FAIL) begin
        retries_d = '0;
      end
    end

    // Outputs decoded from the next state so the registered outputs line up
    // with state_q; this makes the output invariants hold by construction.
    pll_rst_d = (state_d == ST_PLL_RST);
    sys_d     = (state_d == ST_RUN);
    ls_d      = (state_d == ST_RUN);
    fail_d    = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_PLL_RST;
      timer_q   <= '0;
      retries_q <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      sys_q     <= 1'b0;
      ls_q      <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retries_q <= retries_d;
      loss_q    <= loss_d;
      pll_rst_q <= pll_rst_d;
      sys_q     <= sys_d;
      ls_q      <= ls_d;
      fail_q    <= fail_d;
    end
  end

  assign pll_rst         = pll_rst_q;
  assign sys_reset_n     = sys_q;
  assign locked_stable   = ls_q;
  assign fail            = fail_q;
  assign lock_loss_count = loss_q;
  assign state_dbg       = state_q;

endmodule
